// File: rtl/score_pkg.sv
// Shared types and address helpers for the score-matrix controller.
// Used by score_matrix_ctrl and score_ram.
package score_pkg;

   typedef enum logic [2:0] {
      IDLE,
      INIT,
      RD_D,
      RD_U,
      RD_L,
      RD_OUT
   } state_t;

   localparam int DW_DEF = 9;

   function automatic int addr_w(input int n, input int m);
      return $clog2((n + 1) * (m + 1));
   endfunction

   function automatic int cell_addr(input int r, input int c, input int m);
      return r * (m + 1) + c;
   endfunction

endpackage

// File: rtl/score_ram.sv
// 1R1W synchronous score RAM, one-cycle read latency.
// A same-cycle write to the read address is forwarded to the output.
module score_ram
   import score_pkg::*;
#(
   parameter int DW = DW_DEF,
   parameter int AW = 6,
   parameter int D  = 36
) (
   input  logic          clk,
   input  logic          i_we,
   input  logic [AW-1:0] i_waddr,
   input  logic [DW-1:0] i_wdata,
   input  logic [AW-1:0] i_raddr,
   output logic [DW-1:0] o_rdata
);

   logic [DW-1:0] r_mem [D];
   logic [DW-1:0] r_q;

   always_ff @(posedge clk) begin
      if (i_we) r_mem[i_waddr] <= i_wdata;
      if (i_we && (i_waddr == i_raddr)) r_q <= i_wdata;
      else if (int'(i_raddr) < D) r_q <= r_mem[i_raddr];
      else r_q <= '0;
   end

   assign o_rdata = r_q;

endmodule

// File: rtl/score_matrix_ctrl.sv
// Score-matrix controller: border init, neighbour reads, interior writes.
// Define SCORE_MAX_TRACK_EN to add global-maximum tracking outputs.
module score_matrix_ctrl
   import score_pkg::*;
#(
   parameter int N   = 5,
   parameter int M   = 5,
   parameter int DW  = DW_DEF,
   parameter int GAP = -2,
   localparam int IW = ($clog2(N) > 1) ? $clog2(N) : 1,
   localparam int JW = ($clog2(M) > 1) ? $clog2(M) : 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 init_start,
   output logic                 init_done,
   input  logic                 wr_en,
   input  logic [IW-1:0]        wr_i,
   input  logic [JW-1:0]        wr_j,
   input  logic signed [DW-1:0] wr_data,
   output logic                 wr_err,
   input  logic                 rd_req,
   input  logic [IW-1:0]        rd_i,
   input  logic [JW-1:0]        rd_j,
   output logic                 rd_busy,
   output logic                 rd_valid,
   output logic signed [DW-1:0] diag,
   output logic signed [DW-1:0] up,
   output logic signed [DW-1:0] left,
   output logic                 done,
   output logic signed [DW-1:0] final_score
`ifdef SCORE_MAX_TRACK_EN
   ,
   output logic signed [DW-1:0] max_score,
   output logic [IW:0]          max_i,
   output logic [JW:0]          max_j
`endif
);

   localparam int AW = addr_w(N, M);
   localparam int D  = (N + 1) * (M + 1);
   localparam int CW = $clog2(N + M + 2);

   function automatic logic [DW-1:0] border(input int k);
      int t;
      t = k * GAP;
      return t[DW-1:0];
   endfunction

   state_t r_state;
   logic [CW-1:0] r_cnt;
   logic [IW-1:0] r_ri;
   logic [JW-1:0] r_rj;
   logic [DW-1:0] r_td;
   logic [DW-1:0] r_tu;
   logic [DW-1:0] r_diag;
   logic [DW-1:0] r_up;
   logic [DW-1:0] r_left;
   logic [DW-1:0] r_final;
   logic r_init_done;
   logic r_rd_valid;
   logic r_wr_err;
   logic r_done;

   logic w_in_rng;
   logic w_wr_ok;
   logic w_last_cell;
   logic w_we;
   logic [AW-1:0] w_waddr;
   logic [DW-1:0] w_wdata;
   logic [AW-1:0] w_raddr;
   logic [DW-1:0] w_q;

   assign w_in_rng = (int'(wr_i) <= N - 1) && (int'(wr_j) <= M - 1);
   assign w_wr_ok  = wr_en && w_in_rng && (r_state != INIT);
   assign w_last_cell = (int'(wr_i) == N - 1) && (int'(wr_j) == M - 1);

   // INIT owns the write port; interior writes use it otherwise
   always_comb begin
      w_we    = 1'b0;
      w_waddr = '0;
      w_wdata = '0;
      if (r_state == INIT) begin
         if (int'(r_cnt) <= N) begin
            w_we    = 1'b1;
            w_waddr = AW'(cell_addr(int'(r_cnt), 0, M));
            w_wdata = border(int'(r_cnt));
         end else if (int'(r_cnt) <= N + M) begin
            w_we    = 1'b1;
            w_waddr = AW'(cell_addr(0, int'(r_cnt) - N, M));
            w_wdata = border(int'(r_cnt) - N);
         end
      end else if (w_wr_ok) begin
         w_we    = 1'b1;
         w_waddr = AW'(cell_addr(int'(wr_i) + 1, int'(wr_j) + 1, M));
         w_wdata = wr_data;
      end
   end

   always_comb begin
      w_raddr = '0;
      case (r_state)
         RD_D:    w_raddr = AW'(cell_addr(int'(r_ri), int'(r_rj), M));
         RD_U:    w_raddr = AW'(cell_addr(int'(r_ri), int'(r_rj) + 1, M));
         RD_L:    w_raddr = AW'(cell_addr(int'(r_ri) + 1, int'(r_rj), M));
         default: w_raddr = '0;
      endcase
   end

   score_ram #(
      .DW(DW),
      .AW(AW),
      .D (D)
   ) u_ram (
      .clk    (clk),
      .i_we   (w_we),
      .i_waddr(w_waddr),
      .i_wdata(w_wdata),
      .i_raddr(w_raddr),
      .o_rdata(w_q)
   );

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state     <= IDLE;
         r_cnt       <= '0;
         r_ri        <= '0;
         r_rj        <= '0;
         r_td        <= '0;
         r_tu        <= '0;
         r_diag      <= '0;
         r_up        <= '0;
         r_left      <= '0;
         r_final     <= '0;
         r_init_done <= 1'b0;
         r_rd_valid  <= 1'b0;
         r_wr_err    <= 1'b0;
         r_done      <= 1'b0;
      end else begin
         r_init_done <= 1'b0;
         r_rd_valid  <= 1'b0;
         r_done      <= 1'b0;
         r_wr_err    <= wr_en && !w_wr_ok;
         if (w_wr_ok && w_last_cell) begin
            r_done  <= 1'b1;
            r_final <= wr_data;
         end
         // RAM data lags its address by one state
         case (r_state)
            IDLE: begin
               if (init_start) begin
                  r_state <= INIT;
                  r_cnt   <= '0;
               end else if (rd_req) begin
                  r_ri    <= rd_i;
                  r_rj    <= rd_j;
                  r_state <= RD_D;
               end
            end
            INIT: begin
               if (int'(r_cnt) == N + M + 1) begin
                  r_init_done <= 1'b1;
                  r_state     <= IDLE;
               end else begin
                  r_cnt <= r_cnt + CW'(1);
               end
            end
            RD_D: r_state <= RD_U;
            RD_U: begin
               r_td    <= w_q;
               r_state <= RD_L;
            end
            RD_L: begin
               r_tu    <= w_q;
               r_state <= RD_OUT;
            end
            RD_OUT: begin
               r_diag     <= r_td;
               r_up       <= r_tu;
               r_left     <= w_q;
               r_rd_valid <= 1'b1;
               r_state    <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign init_done   = r_init_done;
   assign wr_err      = r_wr_err;
   assign rd_busy     = (r_state != IDLE);
   assign rd_valid    = r_rd_valid;
   assign diag        = r_diag;
   assign up          = r_up;
   assign left        = r_left;
   assign done        = r_done;
   assign final_score = r_final;

`ifdef SCORE_MAX_TRACK_EN
   logic [DW-1:0] r_max;
   logic [IW:0]   r_max_i;
   logic [JW:0]   r_max_j;
   logic          r_max_vld;

   // strict compare so ties keep the earliest cell
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_max     <= '0;
         r_max_i   <= '0;
         r_max_j   <= '0;
         r_max_vld <= 1'b0;
      end else if (w_wr_ok &&
                   (!r_max_vld || (wr_data > $signed(r_max)))) begin
         r_max     <= wr_data;
         r_max_i   <= {1'b0, wr_i} + (IW + 1)'(1);
         r_max_j   <= {1'b0, wr_j} + (JW + 1)'(1);
         r_max_vld <= 1'b1;
      end
   end

   assign max_score = r_max;
   assign max_i     = r_max_i;
   assign max_j     = r_max_j;
`endif

endmodule

// File: tb/tb_score_matrix_ctrl.sv
// Directed bench for score_matrix_ctrl (N=M=5, DW=9, GAP=-2).
// Max-tracking checks run only when SCORE_MAX_TRACK_EN is defined.
module tb_score_matrix_ctrl;

   localparam int N   = 5;
   localparam int M   = 5;
   localparam int DW  = 9;
   localparam int GAP = -2;
   localparam int IW  = 3;
   localparam int JW  = 3;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic init_start = 1'b0;
   logic init_done;
   logic wr_en = 1'b0;
   logic [IW-1:0] wr_i = '0;
   logic [JW-1:0] wr_j = '0;
   logic signed [DW-1:0] wr_data = '0;
   logic wr_err;
   logic rd_req = 1'b0;
   logic [IW-1:0] rd_i = '0;
   logic [JW-1:0] rd_j = '0;
   logic rd_busy;
   logic rd_valid;
   logic signed [DW-1:0] diag;
   logic signed [DW-1:0] up;
   logic signed [DW-1:0] left;
   logic done;
   logic signed [DW-1:0] final_score;
`ifdef SCORE_MAX_TRACK_EN
   logic signed [DW-1:0] max_score;
   logic [IW:0] max_i;
   logic [JW:0] max_j;
`endif

   int total = 0;
   int bad = 0;

   always #5 clk = ~clk;

   score_matrix_ctrl #(
      .N  (N),
      .M  (M),
      .DW (DW),
      .GAP(GAP)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .init_start (init_start),
      .init_done  (init_done),
      .wr_en      (wr_en),
      .wr_i       (wr_i),
      .wr_j       (wr_j),
      .wr_data    (wr_data),
      .wr_err     (wr_err),
      .rd_req     (rd_req),
      .rd_i       (rd_i),
      .rd_j       (rd_j),
      .rd_busy    (rd_busy),
      .rd_valid   (rd_valid),
      .diag       (diag),
      .up         (up),
      .left       (left),
      .done       (done),
      .final_score(final_score)
`ifdef SCORE_MAX_TRACK_EN
      ,
      .max_score  (max_score),
      .max_i      (max_i),
      .max_j      (max_j)
`endif
   );

   task automatic chk(input string tag, input int got, input int exp);
      total++;
      if (got != exp) begin
         bad++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic do_wr(input int i, input int j, input int d);
      wr_en   = 1'b1;
      wr_i    = IW'(i);
      wr_j    = JW'(j);
      wr_data = DW'(d);
      tick;
      wr_en = 1'b0;
   endtask

   task automatic run_init(input bit poke);
      int lat;
      int nv;
      init_start = 1'b1;
      tick;
      init_start = 1'b0;
      chk("init_busy", rd_busy, 1);
      lat = 0;
      nv = 0;
      while (!init_done && lat < 50) begin
         if (poke && lat == 3) begin
            wr_en   = 1'b1;
            wr_i    = 3'd0;
            wr_j    = 3'd0;
            wr_data = 9'sd55;
            rd_req  = 1'b1;
            rd_i    = 3'd2;
            rd_j    = 3'd2;
         end
         tick;
         lat++;
         if (poke && lat == 4) begin
            chk("init_wr_err", wr_err, 1);
            chk("init_busy_poke", rd_busy, 1);
            wr_en  = 1'b0;
            rd_req = 1'b0;
         end
         nv += int'(rd_valid);
      end
      chk("init_lat", lat, 12);
      chk("init_done", init_done, 1);
      if (poke) chk("init_rd_ignored", nv, 0);
      tick;
      chk("init_done_pulse", init_done, 0);
      chk("init_idle", rd_busy, 0);
   endtask

   task automatic run_read(input int i, input int j,
                           input int ed, input int eu, input int el);
      int lat;
      rd_req = 1'b1;
      rd_i   = IW'(i);
      rd_j   = JW'(j);
      tick;
      rd_req = 1'b0;
      chk("rd_busy", rd_busy, 1);
      lat = 0;
      while (!rd_valid && lat < 20) begin
         tick;
         lat++;
      end
      chk("rd_lat", lat, 4);
      chk("rd_diag", diag, ed);
      chk("rd_up", up, eu);
      chk("rd_left", left, el);
      tick;
      chk("rd_valid_pulse", rd_valid, 0);
      chk("rd_hold_left", left, el);
   endtask

   initial begin
      int nv;
      int lat;
      tick;
      tick;
      chk("rst_busy", rd_busy, 0);
      chk("rst_valid", rd_valid, 0);
      chk("rst_init_done", init_done, 0);
      chk("rst_done", done, 0);
      chk("rst_wr_err", wr_err, 0);
      chk("rst_diag", diag, 0);
      chk("rst_final", final_score, 0);
      rst = 1'b1;
      tick;

      run_init(1'b0);
      run_read(0, 0, 0, -2, -2);

      do_wr(0, 0, 1);
      chk("wr_ok_err", wr_err, 0);
      run_read(0, 1, -2, -4, 1);

      run_init(1'b1);
      run_read(0, 1, -2, -4, 1);

      do_wr(4, 4, 7);
      chk("done_pulse", done, 1);
      chk("final_score", final_score, 7);
      chk("last_wr_err", wr_err, 0);
      tick;
      chk("done_clear", done, 0);
      do_wr(5, 0, 3);
      chk("oob_i_err", wr_err, 1);
      chk("oob_i_nodone", done, 0);
      do_wr(0, 5, 3);
      chk("oob_j_err", wr_err, 1);
      chk("oob_final_kept", final_score, 7);

      rd_req = 1'b1;
      rd_i   = 3'd0;
      rd_j   = 3'd1;
      tick;
      rd_req = 1'b0;
      tick;
      chk("rd_u_busy", rd_busy, 1);
      rst = 1'b0;
      tick;
      rst = 1'b1;
      chk("mid_rst_diag", diag, 0);
      chk("mid_rst_up", up, 0);
      chk("mid_rst_left", left, 0);
      chk("mid_rst_final", final_score, 0);
      chk("mid_rst_busy", rd_busy, 0);
      nv = 0;
      for (int k = 0; k < 6; k++) begin
         tick;
         nv += int'(rd_valid);
      end
      chk("mid_rst_no_valid", nv, 0);
      run_read(0, 1, -2, -4, 1);

`ifdef SCORE_MAX_TRACK_EN
      do_wr(0, 0, 3);
      do_wr(1, 2, 9);
      do_wr(3, 3, 9);
      chk("max_score", max_score, 9);
      chk("max_i", max_i, 2);
      chk("max_j", max_j, 3);
`endif

      rd_req = 1'b1;
      rd_i   = 3'd1;
      rd_j   = 3'd1;
      tick;
      rd_req  = 1'b0;
      wr_en   = 1'b1;
      wr_i    = 3'd0;
      wr_j    = 3'd0;
      wr_data = 9'sd13;
      tick;
      wr_en = 1'b0;
      lat = 1;
      while (!rd_valid && lat < 20) begin
         tick;
         lat++;
      end
      chk("fwd_lat", lat, 4);
      chk("fwd_diag", diag, 13);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
